// File: rtl/core_instr_queue_if.sv
// Dispatcher/core-facing bundle of the per-core instruction queue: push side, issue side,
// occupancy status and hazard lookup.
interface core_instr_queue_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic [WIDTH-1:0] push_instr;
  logic             push_ready;
  logic             flush;
  logic             issue_valid;
  logic [WIDTH-1:0] issue_instr;
  logic             issue_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [11:0]      query_src;
  logic [11:0]      query_dest;
  logic             hazard;

  modport master (
    output push, push_instr, flush, issue_ready, query_src, query_dest,
    input  push_ready, issue_valid, issue_instr, count, full, empty, overflow, hazard
  );

  modport slave (
    input  push, push_instr, flush, issue_ready, query_src, query_dest,
    output push_ready, issue_valid, issue_instr, count, full, empty, overflow, hazard
  );
endinterface

// File: rtl/core_instr_queue.sv
// In-order circular instruction buffer feeding one core over valid/ready; 1-cycle push-to-issue,
// pushes dropped (sticky overflow) when full. Combinational hazard lookup over the live window.
module core_instr_queue #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  core_instr_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             full_w, empty_w, push_acc, pop;
  logic             hazard_w;
  logic [AW-1:0]    off_w;
  logic [11:0]      dkey_w, skey_w;

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign push_acc = q.push && !full_w && !q.flush;
  assign pop      = !empty_w && q.issue_ready && !q.flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (q.push & full_w);
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset or cleared on flush; the live window masks stale slots.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= q.push_instr;
  end

  // A slot is live when its distance from the head is below the occupancy count.
  always_comb begin
    hazard_w = 1'b0;
    off_w    = '0;
    dkey_w   = '0;
    skey_w   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_w  = AW'(i) - rd_ptr_q;
      dkey_w = {mem_q[i][22], mem_q[i][21:11]};
      skey_w = {mem_q[i][23], mem_q[i][10:0]};
      if (({1'b0, off_w} < count_q) &&
          (dkey_w == q.query_src || dkey_w == q.query_dest || skey_w == q.query_dest))
        hazard_w = 1'b1;
    end
  end

  assign q.push_ready  = !full_w;
  assign q.issue_valid = !empty_w;
  assign q.issue_instr = empty_w ? '0 : mem_q[rd_ptr_q];
  assign q.count       = count_q;
  assign q.full        = full_w;
  assign q.empty       = empty_w;
  assign q.overflow    = overflow_q;
  assign q.hazard      = hazard_w;
endmodule
